// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and constants for the arbiter requester slice.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_REQ     = 2'd1,
    ARB_BACKOFF = 2'd2
  } arb_req_state_e;

  localparam int ARB_WAIT_W = 16;

endpackage

`default_nettype wire

// File: rtl/arb_req_fifo.sv
// ============================================================================
// Module      : arb_req_fifo
// Description : Synchronous FIFO with head-of-queue read, count and full flag.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_req_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_head,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CNT_W'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/arb_requester.sv
// ============================================================================
// Module      : arb_requester
// Description : Arbiter client: buffers producer words, requests the shared
//               path with a burst cap, and registers granted words out.
//               Optional ARB_REQUESTER_STATS_EN adds the wait_max output.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module arb_requester
  import arb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req,
  input  logic              gnt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              err
`ifdef ARB_REQUESTER_STATS_EN
  ,
  output logic [ARB_WAIT_W-1:0] wait_max
`endif
);

  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int BURST_W = $clog2(MAX_BURST + 1);

  arb_req_state_e     r_state;
  arb_req_state_e     w_state_nxt;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] w_burst_nxt;
  logic [BURST_W-1:0] w_burst_inc;
  logic [CNT_W-1:0]   w_count;
  logic [DATA_W-1:0]  w_head;
  logic               w_full;
  logic               w_push;
  logic               w_xfer;
  logic               w_last;
  logic               w_has_data;

  arb_req_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_xfer),
    .i_wdata (in_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full)
  );

  // req decodes the state register only, so gnt never loops back into it.
  assign req         = (r_state == ARB_REQ);
  assign in_ready    = !w_full;
  assign w_push      = in_valid && !w_full;
  assign w_xfer      = req && gnt;
  assign w_last      = w_xfer && (w_count == CNT_W'(1)) && !w_push;
  assign w_has_data  = (w_count != '0) || w_push;
  assign w_burst_inc = r_burst + BURST_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    case (r_state)
      ARB_IDLE: begin
        if (w_has_data) w_state_nxt = ARB_REQ;
      end
      ARB_REQ: begin
        if (w_xfer) begin
          if (w_last) begin
            w_state_nxt = ARB_IDLE;
            w_burst_nxt = '0;
          end else if (w_burst_inc == BURST_W'(MAX_BURST)) begin
            w_state_nxt = ARB_BACKOFF;
            w_burst_nxt = '0;
          end else begin
            w_burst_nxt = w_burst_inc;
          end
        end
      end
      ARB_BACKOFF: begin
        w_state_nxt = w_has_data ? ARB_REQ : ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_burst_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_burst   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_burst   <= w_burst_nxt;
      out_valid <= w_xfer;
      if (w_xfer)       out_data <= w_head;
      if (gnt && !req)  err      <= 1'b1;
    end
  end

`ifdef ARB_REQUESTER_STATS_EN
  logic [ARB_WAIT_W-1:0] r_wait_run;
  logic [ARB_WAIT_W-1:0] r_wait_max;
  logic [ARB_WAIT_W-1:0] w_wait_inc;

  assign w_wait_inc = (&r_wait_run) ? r_wait_run : r_wait_run + ARB_WAIT_W'(1);

  // The run only grows while stalled in REQ; any grant or exit from REQ ends it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_run <= '0;
      r_wait_max <= '0;
    end else if (req && !gnt) begin
      r_wait_run <= w_wait_inc;
      if (w_wait_inc > r_wait_max) r_wait_max <= w_wait_inc;
    end else begin
      r_wait_run <= '0;
    end
  end

  assign wait_max = r_wait_max;
`endif

endmodule

`default_nettype wire

// File: tb/tb_arb_requester.sv
// ============================================================================
// Module      : tb_arb_requester
// Description : Randomized scoreboard bench for arb_requester against a
//               queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arb_requester;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 4;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              req;
  logic              gnt;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              err;
`ifdef ARB_REQUESTER_STATS_EN
  logic [15:0]       wait_max;
`endif

  arb_requester #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .req       (req),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .err       (err)
`ifdef ARB_REQUESTER_STATS_EN
    ,
    .wait_max  (wait_max)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: words held, whether a request is outstanding, grants in
  // the current run, sticky error and stall statistics.
  logic [DATA_W-1:0] m_fifo[$];
  logic [DATA_W-1:0] exp_q[$];
  bit                m_req;
  bit                m_err;
  int                m_burst;
  int                m_run;
  int                m_wmax;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_req   = 1'b0;
    m_err   = 1'b0;
    m_burst = 0;
    m_run   = 0;
    m_wmax  = 0;
  endtask

  task automatic check_outputs();
    chk("req", 64'(req), 64'(m_req));
    chk("in_ready", 64'(in_ready), 64'(m_fifo.size() < DEPTH));
    chk("err", 64'(err), 64'(m_err));
`ifdef ARB_REQUESTER_STATS_EN
    chk("wait_max", 64'(wait_max), 64'(m_wmax));
`endif
  endtask

  task automatic model_step();
    bit push;
    bit xfer;
    push = in_valid && (m_fifo.size() < DEPTH);
    xfer = m_req && gnt;
    if (gnt && !m_req) m_err = 1'b1;
    if (m_req && !gnt) begin
      if (m_run < 65535) m_run++;
      if (m_run > m_wmax) m_wmax = m_run;
    end else begin
      m_run = 0;
    end
    if (xfer) exp_q.push_back(m_fifo.pop_front());
    if (push) m_fifo.push_back(in_data);
    if (m_req) begin
      if (xfer) begin
        m_burst++;
        if (m_fifo.size() == 0 || m_burst == MAX_BURST) begin
          m_req   = 1'b0;
          m_burst = 0;
        end
      end
    end else begin
      // Idle and the forced drop both re-request as soon as data is held.
      m_req = (m_fifo.size() > 0);
    end
  endtask

  // gmode: 0 no grant, 1 grant follows req, 2 grant forced high, 3 random.
  task automatic step(input bit v, input logic [DATA_W-1:0] d, input int gmode);
    @(negedge clk);
    check_outputs();
    in_valid = v;
    in_data  = d;
    case (gmode)
      0:       gnt = 1'b0;
      1:       gnt = req;
      2:       gnt = 1'b1;
      default: gnt = req ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 63) == 0);
    endcase
    model_step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    gnt      = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_req", 64'(req), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_err", 64'(err), 64'(0));
    rst = 1'b0;
  endtask

  // Monitor: every out_valid beat must match the oldest expected word.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst && out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out_valid", 64'(out_valid), 64'(0));
        else                   chk("out_data", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    gnt      = 1'b0;
    model_reset();
    do_reset();

    // Single word, grant tied to req.
    step(1'b1, 32'hA5, 1);
    repeat (4) step(1'b0, '0, 1);
    chk("single_out_data", 64'(out_data), 64'h0A5);

    // Burst cap with six words queued back to back.
    for (int i = 0; i < 6; i++) step(1'b1, 32'h100 + i, 1);
    repeat (12) step(1'b0, '0, 1);

    // Stalled grant: five REQ cycles without gnt.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h200 + i, 0);
    repeat (3) step(1'b0, '0, 0);
    repeat (6) step(1'b0, '0, 1);
`ifdef ARB_REQUESTER_STATS_EN
    chk("wait_max_stall", 64'(wait_max), 64'(5));
`endif

    // Full FIFO: fifth offer refused, one grant frees a slot.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + i, 0);
    step(1'b0, '0, 1);
    step(1'b0, '0, 0);
    repeat (10) step(1'b0, '0, 1);

    // Spurious grant while idle sets the sticky error.
    step(1'b0, '0, 2);
    repeat (3) step(1'b0, '0, 0);
    step(1'b1, 32'h400, 1);
    repeat (3) step(1'b0, '0, 1);

    // Asynchronous reset in the middle of a transfer cycle.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 32'h500 + i, 1);
    step(1'b0, '0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_req", 64'(req), 64'(0));
    chk("async_out_valid", 64'(out_valid), 64'(0));
    chk("async_in_ready", 64'(in_ready), 64'(1));
    model_reset();
    gnt      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(1'b0, '0, 1);

    // Randomized traffic.
    do_reset();
    repeat (3000) step(1'($urandom_range(0, 1)), $urandom, 3);
    repeat (30) step(1'b0, '0, 1);
    @(negedge clk);
    chk("pending_words", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
